// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster constants and helpers
// for the display timing generator.
package vga_pkg;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic SYNC_NEG = 1'b0;
  localparam logic SYNC_POS = 1'b1;

  function automatic int unsigned h_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pixel_prescaler.sv
// pixel_prescaler: divides the system clock down to a
// one-clock pixel tick.
module pixel_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] p;
  logic          tick_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p      <= '0;
      tick_q <= 1'b0;
    end else if (enable) begin
      tick_q <= (p == PMAX);
      p      <= (p == PMAX) ? '0 : p + 1'b1;
    end
  end

  // A pending tick survives a pause and fires on resume.
  assign tick = tick_q & enable;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster sweep counters with registered sync,
// active-video and line/frame markers.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter logic        SYNC_ACTIVE = SYNC_NEG,
  localparam int unsigned H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW = $clog2(H_TOTAL),
  localparam int unsigned YW = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pixel_tick,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END =
    XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END =
    YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic          hs_on;
  logic          vs_on;
  logic          ls_d;
  logic          fs_d;
  logic          ls_q;
  logic          fs_q;

  pixel_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (pixel_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pixel_tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // x still holds the previous hc, so a nonzero x marks a fresh wrap.
  always_comb begin
    hs_on = (hc >= HS_BEG) && (hc <= HS_END);
    vs_on = (vc >= VS_BEG) && (vc <= VS_END);
    ls_d  = (hc == '0) && (x != '0);
    fs_d  = ls_d && (vc == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      x      <= hc;
      y      <= vc;
      active <= (hc < H_VIS) && (vc < V_VIS);
      hsync  <= hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync  <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      if (fs_d) frame_count <= frame_count + 16'd1;
    end
  end

  assign line_start  = ls_q & enable;
  assign frame_start = fs_q & enable;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random enable/reset stimulus on three rasters,
// checked against an arithmetic pixel-count model.
module tb_vga_timing;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b0;

  always #5 clock = ~clock;

  logic        d_tk, d_ac, d_hs, d_vs, d_ls, d_fs;
  logic [9:0]  d_x;
  logic [9:0]  d_y;
  logic [15:0] d_fc;

  logic        s_tk, s_ac, s_hs, s_vs, s_ls, s_fs;
  logic [2:0]  s_x;
  logic [2:0]  s_y;
  logic [15:0] s_fc;

  logic        f_tk, f_ac, f_hs, f_vs, f_ls, f_fs;
  logic [2:0]  f_x;
  logic [2:0]  f_y;
  logic [15:0] f_fc;

  vga_timing u_def (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .pixel_tick  (d_tk),
    .x           (d_x),
    .y           (d_y),
    .active      (d_ac),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing #(
    .CLK_DIV (2),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .pixel_tick  (s_tk),
    .x           (s_x),
    .y           (s_y),
    .active      (s_ac),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  vga_timing #(
    .CLK_DIV (1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_fast (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .pixel_tick  (f_tk),
    .x           (f_x),
    .y           (f_y),
    .active      (f_ac),
    .hsync       (f_hs),
    .vsync       (f_vs),
    .line_start  (f_ls),
    .frame_start (f_fs),
    .frame_count (f_fc)
  );

  int n_chk = 0;
  int n_err = 0;
  int e     = 0;
  int off_s = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input int n, input int d);
    return (n < 1) ? 0 : (n - 1) / d;
  endfunction

  // Model: after e enabled edges the counters hold pixel number
  // pos_of(e), and the outputs show the counters one clock later.
  task automatic check_inst(
    input string nm, input int d, input int ht, input int vt,
    input int ha, input int hsb, input int hse,
    input int va, input int vsb, input int vse, input int off,
    input logic tk, input int xo, input int yo, input logic ac,
    input logic hs, input logic vs, input logic ls,
    input logic fs, input int fc
  );
    int p, pp, ex, ey, fsz;
    logic etk, eac, ehs, evs, els, efs;
    int efc;
    fsz = ht * vt;
    etk = enable && (e >= 1) && ((e % d) == 0);
    if (e == 0) begin
      ex = 0; ey = 0; eac = 0; ehs = 1; evs = 1;
      els = 0; efs = 0; efc = 0;
    end else begin
      p   = pos_of(e - 1, d);
      pp  = pos_of(e - 2, d);
      ex  = p % ht;
      ey  = (p / ht) % vt;
      eac = (ex < ha) && (ey < va);
      ehs = !((ex >= hsb) && (ex <= hse));
      evs = !((ey >= vsb) && (ey <= vse));
      els = enable && (e >= 2) && (p != pp) && (ex == 0);
      efs = els && ((p % fsz) == 0);
      efc = (p / fsz + off) & 16'hFFFF;
    end
    chk({nm, ".tick"}, int'(tk), int'(etk));
    chk({nm, ".x"}, xo, ex);
    chk({nm, ".y"}, yo, ey);
    chk({nm, ".active"}, int'(ac), int'(eac));
    chk({nm, ".hsync"}, int'(hs), int'(ehs));
    chk({nm, ".vsync"}, int'(vs), int'(evs));
    chk({nm, ".line_start"}, int'(ls), int'(els));
    chk({nm, ".frame_start"}, int'(fs), int'(efs));
    chk({nm, ".frame_count"}, fc, efc);
  endtask

  task automatic check_all();
    check_inst("def", 4, 800, 525, 640, 656, 751,
               480, 490, 491, 0,
               d_tk, int'(d_x), int'(d_y), d_ac, d_hs, d_vs,
               d_ls, d_fs, int'(d_fc));
    check_inst("small", 2, 8, 5, 4, 5, 6, 2, 3, 3, off_s,
               s_tk, int'(s_x), int'(s_y), s_ac, s_hs, s_vs,
               s_ls, s_fs, int'(s_fc));
    check_inst("fast", 1, 8, 5, 4, 5, 6, 2, 3, 3, 0,
               f_tk, int'(f_x), int'(f_y), f_ac, f_hs, f_vs,
               f_ls, f_fs, int'(f_fc));
  endtask

  initial begin
    int rst_cnt;
    int frz;
    bit frz_done;
    rst_cnt  = 0;
    frz      = 0;
    frz_done = 0;
    @(negedge clock);
    check_all();
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clock);
      if (reset_n && enable) e++;
      check_all();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset_n = 1'b1;
      end else if (cyc < 9000 &&
                   (cyc == 4000 ||
                    $urandom_range(0, 2999) == 0)) begin
        reset_n = 1'b0;
        e       = 0;
        off_s   = 0;
        #1;
        check_all();
        rst_cnt = 3;
      end
      if (frz > 0) begin
        frz--;
        enable = (frz == 0);
      end else if (!frz_done && cyc > 1500 && reset_n &&
                   d_x == 10'd100) begin
        frz_done = 1;
        frz      = 37;
        enable   = 1'b0;
      end else if (cyc < 1500) begin
        enable = 1'b1;
      end else begin
        enable = ($urandom_range(0, 7) != 0);
      end
      if (cyc == 10000) begin
        force u_small.frame_count = 16'hFFFF;
        #1;
        release u_small.frame_count;
        off_s = 16'hFFFF - pos_of(e - 1, 2) / 40;
      end
    end
    chk("freeze_seen", int'(frz_done), 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
